// File: rtl/wb_framedma.sv
// Wishbone frame DMA: a slave register file programs a word-by-word copy from
// SRC to DST, performed as alternating single read/write cycles on the master port.
module wb_framedma #(
  parameter int len_width = 12
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  input  logic        m_rty_i,
  output logic        intr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;

  localparam logic [len_width-1:0] LenOne = len_width'(1);

  state_t               state, state_nxt;
  logic [31:0]          src, dst, data, rd_data;
  logic [len_width-1:0] len;
  logic                 done, err, irq_en, gap, abort_pend;
  logic                 acc, reg_wr, busy, m_term, start_req, abort_req, abort_now;
  logic                 unused_bits;

  // Handshakes: a slave access is taken when stb&cyc are high and ack is low,
  // and acked the next cycle; a master cycle ends on any of ack/err/rty while stb is high.
  assign acc       = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign reg_wr    = acc & wb_we_i;
  assign start_req = reg_wr && (wb_adr_i[3:2] == 2'd3) && wb_dat_i[0];
  assign abort_req = reg_wr && (wb_adr_i[3:2] == 2'd3) && wb_dat_i[5];
  assign abort_now = abort_pend | abort_req;
  assign busy      = (state == RD) || (state == WR);

  // gap forces strobes low for one cycle after every master termination
  assign m_stb_o   = busy & ~gap;
  assign m_cyc_o   = m_stb_o;
  assign m_we_o    = (state == WR) & ~gap;
  assign m_sel_o   = 4'hF;
  assign m_adr_o   = m_stb_o ? ((state == WR) ? dst : src) : 32'h0;
  assign m_dat_o   = m_we_o ? data : 32'h0;
  assign m_term    = m_stb_o & (m_ack_i | m_err_i | m_rty_i);
  assign intr      = done & irq_en;
  assign dbg_state = state;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};

  always_comb begin
    rd_data = 32'h0;
    case (wb_adr_i[3:2])
      2'd0:    rd_data = src;
      2'd1:    rd_data = dst;
      2'd2:    rd_data = {{(32 - len_width){1'b0}}, len};
      default: rd_data = {26'h0, 1'b0, err, irq_en, done, busy, 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_req) state_nxt = (len == '0) ? DONE : RD;
      RD: begin
        if (gap) begin
          if (abort_now) state_nxt = IDLE;
        end else if (m_term) begin
          state_nxt = (m_err_i | m_rty_i | abort_now) ? IDLE : WR;
        end
      end
      WR: begin
        if (gap) begin
          if (abort_now) state_nxt = IDLE;
        end else if (m_term) begin
          if (m_err_i | m_rty_i | abort_now) state_nxt = IDLE;
          else if (len == LenOne)            state_nxt = DONE;
          else                               state_nxt = RD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= 32'h0;
      src        <= 32'h0;
      dst        <= 32'h0;
      len        <= '0;
      data       <= 32'h0;
      done       <= 1'b0;
      err        <= 1'b0;
      irq_en     <= 1'b0;
      gap        <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      if (acc && !wb_we_i) wb_dat_o <= rd_data;
      if (reg_wr) begin
        case (wb_adr_i[3:2])
          2'd0: if (!busy) src <= wb_dat_i;
          2'd1: if (!busy) dst <= wb_dat_i;
          2'd2: if (!busy) len <= wb_dat_i[len_width-1:0];
          default: begin
            irq_en <= wb_dat_i[3];
            if (wb_dat_i[2]) done <= 1'b0;
            if (wb_dat_i[4]) err  <= 1'b0;
          end
        endcase
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            done       <= 1'b0;
            err        <= 1'b0;
            gap        <= 1'b0;
            abort_pend <= 1'b0;
          end
        end
        RD, WR: begin
          if (abort_req) abort_pend <= 1'b1;
          if (gap) begin
            gap <= 1'b0;
          end else if (m_term) begin
            gap <= 1'b1;
            if (m_err_i | m_rty_i) begin
              if (!abort_now) err <= 1'b1;
            end else if (state == RD) begin
              data <= m_dat_i;
            end else begin
              src <= src + 32'd4;
              dst <= dst + 32'd4;
              len <= len - LenOne;
            end
          end
        end
        default: done <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_framedma.sv
// Bench for wb_framedma: bus driver tasks, a memory responder on the master port,
// and a scoreboard of expected reads/writes derived from SRC/DST/LEN arithmetic.
module tb_wb_framedma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
  logic [31:0] m_adr_o, m_dat_o;
  logic [31:0] m_dat_i = '0;
  logic [3:0]  m_sel_o;
  logic        m_we_o, m_cyc_o, m_stb_o;
  logic        m_ack_i = 1'b0, m_err_i = 1'b0, m_rty_i = 1'b0;
  logic        intr;
  logic [1:0]  dbg_state;

  wb_framedma #(.len_width(12)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_sel_o(m_sel_o),
    .m_we_o(m_we_o), .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o),
    .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i),
    .intr(intr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // scoreboard: expected master reads (address) and writes ({address, data})
  logic [31:0] exp_rd_q[$];
  logic [63:0] exp_q[$];
  int ack_delay = 0, err_on_wr = 0, wait_cnt = 0, rd_cnt = 0, wr_cnt = 0, gap_viol = 0;
  bit cyc_seen = 0, prev_stb = 0, prev_we = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h3C5A_96E1) + {a[15:0], a[31:16]};
  endfunction

  // memory responder on the master port
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] ew;
    m_ack_i = 1'b0;
    m_err_i = 1'b0;
    m_rty_i = 1'b0;
    if (m_stb_o && prev_stb && (m_we_o != prev_we)) gap_viol++;
    prev_stb = m_stb_o;
    prev_we  = m_we_o;
    if (m_cyc_o) cyc_seen = 1'b1;
    if (m_cyc_o && m_stb_o) begin
      if (wait_cnt < ack_delay) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        if (m_we_o) begin
          wr_cnt++;
          check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            ew = exp_q.pop_front();
            check("wr_adr", m_adr_o, ew[63:32]);
            check("wr_dat", m_dat_o, ew[31:0]);
          end
          if (wr_cnt == err_on_wr) m_err_i = 1'b1;
          else                     m_ack_i = 1'b1;
        end else begin
          rd_cnt++;
          check("rd_expected", 32'(exp_rd_q.size() > 0), 32'd1);
          if (exp_rd_q.size() > 0) begin
            ea = exp_rd_q.pop_front();
            check("rd_adr", m_adr_o, ea);
          end
          m_dat_i = mem_word(m_adr_o);
          m_ack_i = 1'b1;
        end
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // driver tasks
  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    wb_adr_i = {28'h0, a, 2'b00};
    wb_dat_i = d;
    wb_we_i  = 1'b1;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(negedge clk);
    check("wr_ack", {31'h0, wb_ack_o}, 32'd1);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    wb_adr_i = {28'h0, a, 2'b00};
    wb_we_i  = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(negedge clk);
    check("rd_ack", {31'h0, wb_ack_o}, 32'd1);
    d = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    int n;
    n = 0;
    do begin
      wb_read(2'd3, v);
      n++;
    end while (v[1] && n < 4000);
    check("idle_timeout", {31'h0, v[1]}, 32'd0);
  endtask

  task automatic push_expect(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(s + 32'(4 * i));
      exp_q.push_back({d + 32'(4 * i), mem_word(s + 32'(4 * i))});
    end
  endtask

  task automatic run_transfer(input logic [31:0] s, input logic [31:0] d, input int n,
                              input int delay);
    logic [31:0] v;
    ack_delay = delay;
    rd_cnt = 0;
    wr_cnt = 0;
    push_expect(s, d, n);
    wb_write(2'd0, s);
    wb_write(2'd1, d);
    wb_write(2'd2, 32'(n));
    wb_write(2'd3, 32'h1);
    wait_idle();
    wb_read(2'd3, v); check("xfer_status", v, 32'h4);
    wb_read(2'd2, v); check("xfer_len", v, 32'h0);
    wb_read(2'd0, v); check("xfer_src", v, s + 32'(4 * n));
    wb_read(2'd1, v); check("xfer_dst", v, d + 32'(4 * n));
    check("xfer_rd_cnt", 32'(rd_cnt), 32'(n));
    check("xfer_wr_cnt", 32'(wr_cnt), 32'(n));
    check("xfer_q_empty", 32'(exp_q.size() + exp_rd_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] v, s, d;
    do_reset();

    // reset state
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r), v);
      check("rst_reg", v, 32'h0);
    end
    check("rst_cyc", {31'h0, m_cyc_o}, 32'd0);
    check("rst_intr", {31'h0, intr}, 32'd0);
    check("rst_madr", m_adr_o, 32'h0);
    check("msel", {28'h0, m_sel_o}, 32'hF);

    // slave ack never on two consecutive cycles
    @(negedge clk);
    wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(negedge clk); check("ack_seq0", {31'h0, wb_ack_o}, 32'd1);
    @(negedge clk); check("ack_seq1", {31'h0, wb_ack_o}, 32'd0);
    @(negedge clk); check("ack_seq2", {31'h0, wb_ack_o}, 32'd1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;

    // directed 3-word copy
    run_transfer(32'h4000_0000, 32'h7004_0000, 3, 0);

    // LEN=0 with interrupt enabled
    cyc_seen = 1'b0;
    wb_write(2'd2, 32'h0);
    wb_write(2'd3, 32'h9);
    @(negedge clk);
    check("len0_intr", {31'h0, intr}, 32'd1);
    wb_read(2'd3, v); check("len0_status", v, 32'hC);
    check("len0_no_cyc", {31'h0, cyc_seen}, 32'd0);
    wb_write(2'd3, 32'h4);
    check("len0_intr_clr", {31'h0, intr}, 32'd0);

    // error on the second write
    rd_cnt = 0; wr_cnt = 0; err_on_wr = 2; ack_delay = 0;
    push_expect(32'h1000_0000, 32'h2000_0000, 2);
    wb_write(2'd0, 32'h1000_0000);
    wb_write(2'd1, 32'h2000_0000);
    wb_write(2'd2, 32'd5);
    wb_write(2'd3, 32'h1);
    wait_idle();
    wb_read(2'd3, v); check("err_status", v, 32'h10);
    wb_read(2'd2, v); check("err_len", v, 32'd4);
    check("err_rd_cnt", 32'(rd_cnt), 32'd2);
    check("err_wr_cnt", 32'(wr_cnt), 32'd2);
    err_on_wr = 0;

    // abort during the first read, ack delayed 3 cycles
    rd_cnt = 0; wr_cnt = 0; ack_delay = 3;
    exp_rd_q.push_back(32'h5000_0000);
    wb_write(2'd0, 32'h5000_0000);
    wb_write(2'd1, 32'h6000_0000);
    wb_write(2'd2, 32'd100);
    wb_write(2'd3, 32'h1);
    wb_write(2'd3, 32'h20);
    check("abort_cyc_held", {31'h0, m_cyc_o}, 32'd1);
    wait_idle();
    wb_read(2'd3, v); check("abort_status", v, 32'h0);
    wb_read(2'd2, v); check("abort_len", v, 32'd100);
    check("abort_rd_cnt", 32'(rd_cnt), 32'd1);
    check("abort_wr_cnt", 32'(wr_cnt), 32'd0);

    // address wrap
    run_transfer(32'hFFFF_FFFC, 32'h7004_0000, 2, 1);

    // randomized copies
    for (int t = 0; t < 5; t++) begin
      s = $urandom & 32'hFFFF_FFFC;
      d = $urandom & 32'hFFFF_FFFC;
      run_transfer(s, d, $urandom_range(1, 8), $urandom_range(0, 2));
    end

    // LEN write while busy, then reset in the middle of a write
    ack_delay = 3;
    push_expect(32'h4000_0100, 32'h7004_0100, 20);
    wb_write(2'd0, 32'h4000_0100);
    wb_write(2'd1, 32'h7004_0100);
    wb_write(2'd2, 32'd20);
    wb_write(2'd3, 32'h9);
    wb_write(2'd2, 32'd7);
    wb_read(2'd2, v); check("busy_len_ignored", v, 32'd20);
    begin
      int n;
      n = 0;
      while (!(m_stb_o && m_we_o) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("wr_wait_timeout", {31'h0, m_stb_o & m_we_o}, 32'd1);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_mid_cyc", {31'h0, m_cyc_o}, 32'd0);
    reset_n = 1'b1;
    exp_q.delete();
    exp_rd_q.delete();
    ack_delay = 0;
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r), v);
      check("rst_mid_reg", v, 32'h0);
    end
    check("rst_mid_intr", {31'h0, intr}, 32'd0);
    check("strobe_gap", 32'(gap_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_framedma.md
WB_FRAMEDMA -- requirements
Module: wb_framedma

Interface
REQ-001 Parameter: len_width, 12, width of the transfer-length register in words (max 4095 words).
REQ-002 Decided: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset.
REQ-005 wb_adr_i  input  32  slave register address; only bits [3:2] decoded.
REQ-006 wb_dat_i / wb_dat_o  input / output  32  slave write / read data.
REQ-007 wb_sel_i  input  4  byte selects; ignored, full-word access only.
REQ-008 wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  Wishbone classic slave strobe, cycle and write enable.
REQ-009 wb_ack_o  output  1  slave acknowledge.
REQ-010 m_adr_o, m_dat_o  output  32 each  master address and write data.
REQ-011 m_dat_i  input  32  master read data.
REQ-012 m_sel_o  output  4  master byte selects, constant 4'hF.
REQ-013 m_we_o, m_cyc_o, m_stb_o  output  1 each  master write enable, cycle and strobe.
REQ-014 m_ack_i, m_err_i, m_rty_i  input  1 each  master cycle termination.
REQ-015 intr  output  1  level interrupt: done AND irq_en.

Function
REQ-016 Purpose: copies LEN 32-bit words from SRC (SRAM frame store) to DST (wb_farbborg frame buffer); it attaches as interconnect master m2.
REQ-017 Register map (wb_adr_i[3:2]): 0=SRC, 1=DST, 2=LEN (zero-extended on read), 3=CTRL/STATUS.
REQ-018 CTRL/STATUS bits: [0] start (write-1, reads 0); [1] busy (read-only); [2] done (sticky, write-1-clear); [3] irq_en (r/w); [4] err (sticky, write-1-clear); [5] abort (write-1, reads 0).
REQ-019 Slave ack: wb_ack_o is asserted for exactly one cycle, on the cycle after wb_stb_i&wb_cyc_i is seen with ack low; it is never asserted on two consecutive cycles.
REQ-020 Writes to SRC/DST/LEN while busy=1 are ignored; reads are always valid and return the live working address and count.
REQ-021 FSM states: IDLE, RD, WR, DONE.
REQ-022 IDLE->RD on the cycle after an acked CTRL write with start=1 and LEN!=0; busy=1 and done/err are cleared in that same transition.
REQ-023 Start with LEN=0 -> DONE directly; no master cycle is issued.
REQ-024 RD: m_cyc_o=m_stb_o=1, m_we_o=0, m_adr_o=SRC working pointer; on m_ack_i latch m_dat_i, then ->WR.
REQ-025 WR: m_cyc_o=m_stb_o=m_we_o=1, m_adr_o=DST working pointer, m_dat_o=latched word; on m_ack_i: SRC+=4, DST+=4, count-=1; ->DONE if count reaches 0, else ->RD.
REQ-026 Strobes deassert for at least one cycle between RD and WR; no bursts, cti is not driven.
REQ-027 Address increment wraps modulo 2^32.
REQ-028 m_err_i or m_rty_i in RD/WR -> err=1, master cycle dropped next cycle, ->IDLE, done not set.
REQ-029 Abort while busy: the in-flight master cycle completes (ack/err/rty), then ->IDLE; done=0, err=0. Abort in IDLE has no effect.
REQ-030 Start while busy is ignored.
REQ-031 DONE: lasts one cycle; sets done=1, busy=0, ->IDLE.
REQ-032 SRC/DST/LEN registers hold the working values and end at base+4*LEN, 0.

Reset
REQ-033 With reset_n=0 at a clock edge: state IDLE; SRC=DST=LEN=0; done=err=irq_en=0; busy=0; wb_ack_o=0; m_cyc_o=m_stb_o=m_we_o=0; m_adr_o=m_dat_o=0; intr=0.
REQ-034 Reset mid-transfer drops m_cyc_o/m_stb_o at that edge, with no wait for ack.

Verification
REQ-035 SRC=0x40000000, DST=0x70040000, LEN=3, start -> 3 read/write pairs at 0x40000000/0x70040000, +4, +8; data matches; done=1; LEN reads 0.
REQ-036 LEN=0, irq_en=1, start -> no m_cyc_o, done=1 within 2 cycles, intr=1; write CTRL=0x4 -> intr=0.
REQ-037 LEN=5; m_err_i on the 2nd write -> err=1, done=0, busy=0; exactly 2 reads and 2 writes issued.
REQ-038 LEN=100; abort during RD with ack delayed 3 cycles -> m_cyc_o held until ack, then IDLE; busy=0, done=0.
REQ-039 SRC=0xFFFFFFFC, LEN=2 -> second read at 0x00000000.
REQ-040 Write LEN=7 while busy -> ignored; reset_n=0 mid-WR -> m_cyc_o=0 the following cycle; all registers 0.
